// File: rtl/wb_stage.sv
// Writeback stage: captures the MEM/WB payload, selects the write source and drives the register-file write port.
// Optional feature macro: WB_SUBWORD_LOAD_EN (byte/half load extraction with sign/zero extension).
module wb_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ZERO_REG   = 1,
  parameter int RETIRE_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  hold,
  input  logic                  flush,
  input  logic [1:0]            wb_sel,
  input  logic                  rd_we,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0]     data_from_alu,
  input  logic [DATA_W-1:0]     data_from_mem,
  input  logic [DATA_W-1:0]     pc_plus4,
  input  logic [DATA_W-1:0]     imm,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  input  logic [1:0]            byte_off,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  out_valid,
  output logic [RETIRE_W-1:0]   retire_cnt
);

  logic                  w_capture;
  logic                  w_retire;
  logic                  w_zero_dest;
  logic [DATA_W-1:0]     w_load_data;
  logic [DATA_W-1:0]     w_sel_data;

  logic                  r_valid;
  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0]     r_wdata;
  logic [RETIRE_W-1:0]   r_retire;

`ifdef WB_SUBWORD_LOAD_EN
  function automatic logic [DATA_W-1:0] f_load_extend(
    input logic [DATA_W-1:0] word,
    input logic [1:0]        size,
    input logic              is_unsigned,
    input logic [1:0]        off
  );
    logic [7:0]  v_byte;
    logic [15:0] v_half;
    logic [DATA_W-1:0] v_res;
    v_byte = word[{off, 3'b000} +: 8];
    v_half = word[{off[1], 4'b0000} +: 16];
    case (size)
      2'd0:    v_res = {{(DATA_W-8){v_byte[7] & ~is_unsigned}}, v_byte};
      2'd1:    v_res = {{(DATA_W-16){v_half[15] & ~is_unsigned}}, v_half};
      default: v_res = word;
    endcase
    return v_res;
  endfunction

  assign w_load_data = f_load_extend(data_from_mem, mem_size, mem_unsigned, byte_off);
`else
  logic w_unused_subword;
  assign w_unused_subword = ^{mem_size, mem_unsigned, byte_off};
  assign w_load_data      = data_from_mem;
`endif

  assign in_ready    = ~hold;
  assign w_capture   = in_valid & ~hold & ~flush;
  assign w_retire    = r_valid & ~hold;
  assign w_zero_dest = (ZERO_REG != 0) && (r_waddr == {REG_ADDR_W{1'b0}});

  // Write-source select; every encoding is defined so no X reaches the capture register
  always_comb begin
    w_sel_data = data_from_alu;
    case (wb_sel)
      2'd0:    w_sel_data = data_from_alu;
      2'd1:    w_sel_data = w_load_data;
      2'd2:    w_sel_data = pc_plus4;
      2'd3:    w_sel_data = imm;
      default: w_sel_data = data_from_alu;
    endcase
  end

  // Capture register and retire counter; hold freezes everything, flush only blocks capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_we     <= 1'b0;
      r_waddr  <= {REG_ADDR_W{1'b0}};
      r_wdata  <= {DATA_W{1'b0}};
      r_retire <= {RETIRE_W{1'b0}};
    end else if (!hold) begin
      if (w_capture) begin
        r_valid <= 1'b1;
        r_we    <= rd_we;
        r_waddr <= rd_addr;
        r_wdata <= w_sel_data;
      end else begin
        r_valid <= 1'b0;
      end
      if (w_retire) begin
        r_retire <= r_retire + RETIRE_W'(1);
      end
    end
  end

  assign rf_we      = r_valid & r_we & ~hold & ~w_zero_dest;
  assign rf_waddr   = r_waddr;
  assign rf_wdata   = r_wdata;
  assign out_valid  = r_valid;
  assign retire_cnt = r_retire;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: captured instructions are queued with their expected write
// and checked on the cycle they retire.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, hold, flush;
  logic [1:0]  wb_sel;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] data_from_alu, data_from_mem, pc_plus4, imm;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [1:0]  byte_off;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        out_valid;
  logic [31:0] retire_cnt;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        we;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_retire = 32'd0;

  wb_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .hold(hold), .flush(flush), .wb_sel(wb_sel), .rd_we(rd_we), .rd_addr(rd_addr),
    .data_from_alu(data_from_alu), .data_from_mem(data_from_mem),
    .pc_plus4(pc_plus4), .imm(imm), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .byte_off(byte_off), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .out_valid(out_valid), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_wdata(input logic [1:0] sel, input logic [31:0] alu,
                                              input logic [31:0] mem, input logic [31:0] pc,
                                              input logic [31:0] im, input logic [1:0] size,
                                              input logic uns, input logic [1:0] off);
    logic [31:0] t;
    case (sel)
      2'd0: t = alu;
      2'd2: t = pc;
      2'd3: t = im;
      default: begin
        t = mem;
`ifdef WB_SUBWORD_LOAD_EN
        if (size == 2'd0) begin
          t = (mem >> (off * 8)) & 32'h0000_00FF;
          if (!uns && (t & 32'h80) != 0) t = t | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
          t = (mem >> (off[1] ? 16 : 0)) & 32'h0000_FFFF;
          if (!uns && (t & 32'h8000) != 0) t = t | 32'hFFFF_0000;
        end
`endif
      end
    endcase
    return t;
  endfunction

  // Monitor: checks the retiring entry, then records what the coming edge will capture
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      exp_retire = 32'd0;
    end else begin
      check_eq("in_ready", {63'd0, in_ready}, {63'd0, ~hold});
      check_eq("out_valid", {63'd0, out_valid}, {63'd0, sb_q.size() > 0});
      check_eq("retire_cnt", {32'd0, retire_cnt}, {32'd0, exp_retire});
      if (sb_q.size() > 0) begin
        check_eq("rf_we", {63'd0, rf_we}, {63'd0, sb_q[0].we & ~hold});
        if (sb_q[0].we && !hold) begin
          check_eq("rf_waddr", {59'd0, rf_waddr}, {59'd0, sb_q[0].addr});
          check_eq("rf_wdata", {32'd0, rf_wdata}, {32'd0, sb_q[0].data});
        end
        if (!hold) begin
          void'(sb_q.pop_front());
          exp_retire = exp_retire + 32'd1;
        end
      end else begin
        check_eq("rf_we_idle", {63'd0, rf_we}, 64'd0);
      end
      if (in_valid && !hold && !flush) begin
        sb_q.push_back('{addr: rd_addr,
                         data: model_wdata(wb_sel, data_from_alu, data_from_mem, pc_plus4,
                                           imm, mem_size, mem_unsigned, byte_off),
                         we: rd_we && (rd_addr != 5'd0)});
      end
    end
  end

  task automatic drive(input logic v, input logic [1:0] sel, input logic we,
                       input logic [4:0] addr, input logic [31:0] val,
                       input logic h, input logic f);
    in_valid      = v;
    wb_sel        = sel;
    rd_we         = we;
    rd_addr       = addr;
    data_from_alu = (sel == 2'd0) ? val : 32'h5A5A_0000;
    data_from_mem = (sel == 2'd1) ? val : 32'h0BAD_0001;
    pc_plus4      = (sel == 2'd2) ? val : 32'h0000_0F00;
    imm           = (sel == 2'd3) ? val : 32'h7777_0000;
    hold          = h;
    flush         = f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [31:0] word, input logic [1:0] size,
                      input logic uns, input logic [1:0] off);
    mem_size     = size;
    mem_unsigned = uns;
    byte_off     = off;
    drive(1'b1, 2'd1, 1'b1, 5'd9, word, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    mem_size = 2'd2; mem_unsigned = 1'b0; byte_off = 2'd0;
    in_valid = 1'b0; hold = 1'b0; flush = 1'b0; wb_sel = 2'd0; rd_we = 1'b0; rd_addr = 5'd0;
    data_from_alu = 32'd0; data_from_mem = 32'd0; pc_plus4 = 32'd0; imm = 32'd0;
    #1;
    check_eq("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("reset_rf_we", {63'd0, rf_we}, 64'd0);
    check_eq("reset_rf_waddr", {59'd0, rf_waddr}, 64'd0);
    check_eq("reset_rf_wdata", {32'd0, rf_wdata}, 64'd0);
    check_eq("reset_retire", {32'd0, retire_cnt}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    drive(1'b1, 2'd0, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b0);
    idle(1);
    check_eq("first_retire", {32'd0, retire_cnt}, 64'd1);
    drive(1'b1, 2'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(2);

    drive(1'b1, 2'd1, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 2'd0, 1'b1, 5'd3, 32'h1111_2222, 1'b1, 1'b1);
    idle(2);
    check_eq("retire_after_hold", {32'd0, retire_cnt}, 64'd3);

    drive(1'b1, 2'd0, 1'b1, 5'd1, 32'h0000_00A1, 1'b0, 1'b0);
    drive(1'b1, 2'd0, 1'b1, 5'd2, 32'h0000_00B2, 1'b0, 1'b1);
    idle(2);

    drive(1'b1, 2'd2, 1'b1, 5'd10, 32'h0000_0104, 1'b0, 1'b0);
    drive(1'b1, 2'd3, 1'b1, 5'd11, 32'hABC0_0000, 1'b0, 1'b0);
    idle(1);

`ifdef WB_SUBWORD_LOAD_EN
    load(32'h80FF_7F01, 2'd0, 1'b0, 2'd1);
    load(32'h80FF_7F01, 2'd0, 1'b0, 2'd3);
    load(32'h80FF_7F01, 2'd1, 1'b1, 2'd2);
    load(32'h80FF_7F01, 2'd2, 1'b0, 2'd0);
    idle(1);
`else
    load(32'h80FF_7F01, 2'd0, 1'b0, 2'd1);
    idle(1);
`endif

    for (int i = 0; i < 60; i++) begin
      mem_size     = 2'($urandom_range(0, 3));
      mem_unsigned = 1'($urandom_range(0, 1));
      byte_off     = 2'($urandom_range(0, 3));
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 31)), $urandom(), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 5) == 0));
    end
    idle(2);

    drive(1'b1, 2'd0, 1'b1, 5'd12, 32'h0C0C_0C0C, 1'b0, 1'b0);
    hold = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("async_rf_we", {63'd0, rf_we}, 64'd0);
    check_eq("async_rf_waddr", {59'd0, rf_waddr}, 64'd0);
    check_eq("async_rf_wdata", {32'd0, rf_wdata}, 64'd0);
    check_eq("async_retire", {32'd0, retire_cnt}, 64'd0);
    @(posedge clk); #1;
    hold  = 1'b0;
    rst_n = 1'b1;
    drive(1'b1, 2'd0, 1'b1, 5'd13, 32'h0000_5555, 1'b0, 1'b0);
    idle(2);
    check_eq("final_retire", {32'd0, retire_cnt}, 64'd1);
    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
